// File: rtl/fifo_param_pkg.sv
// fifo_param_pkg: shared types and helpers for the parametrised FIFO.
//   fifo_status_t : packed bundle of the FIFO flags for consumers that
//                   want a single status word.
//   is_pow2()     : constant function used by the elaboration-time
//                   parameter checks in fifo_param.
package fifo_param_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic prog_full;
    logic prog_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// fifo_param_mem: WIDTH x DEPTH storage array, synchronous write port and
// asynchronous read port. Kept separate so a vendor RAM can be dropped in.
// Ports:
//   clk      : clock, write on rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : combinational read data, mem[i_raddr]
module fifo_param_mem #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  // Contents are intentionally never reset.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock first-word-fall-through FIFO with
// programmable full/empty thresholds, exported word count and clearable
// sticky overflow/underflow flags.
// Optional feature: define FIFO_PARAM_PEAK_EN to add peak_cnt, a
// high-water mark of word_cnt cleared by reset_p or err_clr.
// Ports:
//   clk, reset_p           : clock, synchronous active-high reset
//   data_i, data_we        : write data / write request
//   data_o, data_rd        : head-of-queue data / pop request
//   word_cnt               : stored words, 0..DEPTH
//   full, empty            : count == DEPTH / count == 0
//   prog_full, prog_empty  : count >= PROG_FULL / count <= PROG_EMPTY
//   overflow, underflow    : sticky error flags
//   err_clr                : clears the sticky flags (a new error wins)
//   peak_cnt               : high-water mark (FIFO_PARAM_PEAK_EN only)
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int PROG_FULL  = 14,
  parameter int PROG_EMPTY = 2,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CNT_W     = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_we,
  output logic [WIDTH-1:0] data_o,
  input  logic             data_rd,
  output logic [CNT_W-1:0] word_cnt,
  output logic             full,
  output logic             empty,
  output logic             prog_full,
  output logic             prog_empty,
  output logic             overflow,
  output logic             underflow,
`ifdef FIFO_PARAM_PEAK_EN
  output logic [CNT_W-1:0] peak_cnt,
`endif
  input  logic             err_clr
);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_err_width
    $error("fifo_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_err_depth
    $error("fifo_param: DEPTH must be a power of two and >= 2");
  end
  if (PROG_FULL < 1 || PROG_FULL > DEPTH) begin : g_err_pf
    $error("fifo_param: PROG_FULL out of range 1..DEPTH");
  end
  if (PROG_EMPTY < 0 || PROG_EMPTY > DEPTH - 1) begin : g_err_pe
    $error("fifo_param: PROG_EMPTY out of range 0..DEPTH-1");
  end

  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_PF    = CNT_W'(PROG_FULL);
  localparam logic [CNT_W-1:0] LP_PE    = CNT_W'(PROG_EMPTY);

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              r_overflow, r_underflow;
  logic              w_is_write, w_is_read;

  // Accept decisions use pre-edge flags: at the full boundary the read
  // still goes through and the write is dropped; at the empty boundary
  // the write goes through and the read is rejected.
  assign w_is_write = data_we & ~full;
  assign w_is_read  = data_rd & ~empty;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_word_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_is_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_is_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_is_write, w_is_read})
        2'b10:   r_word_cnt <= r_word_cnt + 1'b1;
        2'b01:   r_word_cnt <= r_word_cnt - 1'b1;
        default: r_word_cnt <= r_word_cnt;
      endcase
      // Set has priority over clear.
      if (data_we & full)      r_overflow <= 1'b1;
      else if (err_clr)        r_overflow <= 1'b0;
      if (data_rd & empty)     r_underflow <= 1'b1;
      else if (err_clr)        r_underflow <= 1'b0;
    end
  end

`ifdef FIFO_PARAM_PEAK_EN
  logic [CNT_W-1:0] r_peak_cnt;

  always_ff @(posedge clk) begin
    if (reset_p || err_clr)         r_peak_cnt <= '0;
    else if (r_word_cnt > r_peak_cnt) r_peak_cnt <= r_word_cnt;
  end

  assign peak_cnt = r_peak_cnt;
`endif

  fifo_param_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_is_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_o)
  );

  assign word_cnt   = r_word_cnt;
  assign full       = (r_word_cnt == LP_DEPTH);
  assign empty      = (r_word_cnt == '0);
  assign prog_full  = (r_word_cnt >= LP_PF);
  assign prog_empty = (r_word_cnt <= LP_PE);
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed test-plan steps followed by a randomized phase,
// all checked against a queue-based reference model of the FIFO.
module tb_fifo_param;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int PF = 14;
  localparam int PE = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset_p = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          data_we = 1'b0;
  logic [W-1:0]  data_o;
  logic          data_rd = 1'b0;
  logic [CW-1:0] word_cnt;
  logic          full, empty, prog_full, prog_empty, overflow, underflow;
  logic          err_clr = 1'b0;
`ifdef FIFO_PARAM_PEAK_EN
  logic [CW-1:0] peak_cnt;
`endif

  fifo_param #(.WIDTH(W), .DEPTH(D), .PROG_FULL(PF), .PROG_EMPTY(PE)) dut (
    .clk(clk), .reset_p(reset_p), .data_i(data_i), .data_we(data_we),
    .data_o(data_o), .data_rd(data_rd), .word_cnt(word_cnt),
    .full(full), .empty(empty), .prog_full(prog_full),
    .prog_empty(prog_empty), .overflow(overflow), .underflow(underflow),
`ifdef FIFO_PARAM_PEAK_EN
    .peak_cnt(peak_cnt),
`endif
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: stored words as a queue plus sticky flags.
  logic [W-1:0] m_q[$];
  bit           m_ov, m_un;
  int           m_peak;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = m_q.size();
    chk("word_cnt",   int'(word_cnt),   n);
    chk("full",       int'(full),       int'(n == D));
    chk("empty",      int'(empty),      int'(n == 0));
    chk("prog_full",  int'(prog_full),  int'(n >= PF));
    chk("prog_empty", int'(prog_empty), int'(n <= PE));
    chk("overflow",   int'(overflow),   int'(m_ov));
    chk("underflow",  int'(underflow),  int'(m_un));
    if (n > 0) chk("data_o", int'(data_o), int'(m_q[0]));
`ifdef FIFO_PARAM_PEAK_EN
    chk("peak_cnt",   int'(peak_cnt),   m_peak);
`endif
  endtask

  // One clock: apply inputs at the falling edge, advance the model,
  // then compare after the next falling edge.
  task automatic cyc(input bit we, input bit rd, input logic [W-1:0] d,
                     input bit clr, input bit rst);
    int n;
    data_we = we; data_rd = rd; data_i = d; err_clr = clr; reset_p = rst;
    n = m_q.size();
    if (rst) begin
      m_q.delete(); m_ov = 0; m_un = 0; m_peak = 0;
    end else begin
      if (clr)            m_peak = 0;
      else if (n > m_peak) m_peak = n;
      if (we && n == D)   m_ov = 1; else if (clr) m_ov = 0;
      if (rd && n == 0)   m_un = 1; else if (clr) m_un = 0;
      if (rd && n > 0)    void'(m_q.pop_front());
      if (we && n < D)    m_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    data_we = 0; data_rd = 0; err_clr = 0; reset_p = 0;
    check_all();
  endtask

  initial begin
    @(negedge clk);
    // 1. reset, idle, read while empty
    cyc(0, 0, '0, 0, 1);
    cyc(0, 0, '0, 0, 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_cnt", int'(word_cnt), 0);
    cyc(0, 1, '0, 0, 0);
    chk("underflow_set", int'(underflow), 1);
    cyc(0, 0, '0, 1, 0);
    // 2. fill, overflow, drain
    for (int i = 1; i <= 16; i++) cyc(1, 0, W'(i), 0, 0);
    chk("full_after16", int'(full), 1);
    cyc(1, 0, 16'hDEAD, 0, 0);
    chk("overflow_set", int'(overflow), 1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", int'(data_o), i);
      cyc(0, 1, '0, 0, 0);
    end
    chk("drained_empty", int'(empty), 1);
    cyc(0, 0, '0, 1, 0);
    // 3. wrap-around
    for (int i = 0; i < 10; i++) cyc(1, 0, W'(i + 32), 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, '0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, W'(16'h0100 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_data", int'(data_o), 16'h0100 + i);
      cyc(0, 1, '0, 0, 0);
    end
    // 4. simultaneous ops at boundaries
    for (int i = 0; i < 16; i++) cyc(1, 0, W'(16'h0200 + i), 0, 0);
    cyc(1, 1, 16'hBEEF, 0, 0);
    chk("full_rw_cnt", int'(word_cnt), 15);
    chk("full_rw_head", int'(data_o), 16'h0201);
    for (int i = 0; i < 15; i++) cyc(0, 1, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    cyc(1, 1, 16'h00AA, 0, 0);
    chk("empty_rw_cnt", int'(word_cnt), 1);
    chk("empty_rw_data", int'(data_o), 16'h00AA);
    chk("empty_rw_un", int'(underflow), 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(16'h0300 + i), 0, 0);
    cyc(1, 1, 16'h0333, 0, 0);
    chk("mid_rw_cnt", int'(word_cnt), 5);
    // 5. sticky clear
    for (int i = 0; i < 11; i++) cyc(1, 0, W'(16'h0400 + i), 0, 0);
    cyc(1, 0, 16'h0BAD, 0, 0);
    cyc(0, 0, '0, 1, 0);
    chk("ov_cleared", int'(overflow), 0);
    cyc(1, 0, 16'h0BAD, 1, 0);
    chk("ov_set_wins", int'(overflow), 1);
    // 6. reset mid-stream
    cyc(0, 0, '0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(1, 0, W'(16'h0500 + i), 0, 0);
    cyc(0, 0, '0, 0, 0);
    cyc(1, 0, 16'h0FFF, 0, 1);
    chk("rst_cnt", int'(word_cnt), 0);
    chk("rst_empty", int'(empty), 1);
    cyc(1, 0, 16'h0777, 0, 0);
    chk("rst_no_store", int'(data_o), 16'h0777);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      bit we, rd, clr, rst;
      int bias;
      bias = (i / 300) % 3;
      we  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      rd  = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cyc(we, rd, W'($urandom), clr, rst);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised successor to the team's simple synchronous FIFO, with width and depth set by parameters and pointer and count widths derived from depth. Adds a programmable almost-empty flag, an exported word count, clearable sticky error flags and a defined priority for simultaneous read and write at the boundaries. Single clock domain; it sits between a producer and consumer such as the calculator command and result paths.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of two and >=2
PROG_FULL, 14, prog_full asserts when word_cnt >= PROG_FULL; legal range 1..DEPTH
PROG_EMPTY, 2, prog_empty asserts when word_cnt <= PROG_EMPTY; legal range 0..DEPTH-1
Derived localparam ADDR_W = $clog2(DEPTH); CNT_W = ADDR_W+1.

Ports:
clk  input  1  clock; all state on rising edge
reset_p  input  1  synchronous active-high reset; one clock, sampled directly with no extra register stage
data_i  input  WIDTH  write data
data_we  input  1  write request
data_o  output  WIDTH  head-of-queue data, first-word-fall-through
data_rd  input  1  read request; pops the word currently on data_o
word_cnt  output  CNT_W  number of stored words, 0..DEPTH
full  output  1  word_cnt == DEPTH
empty  output  1  word_cnt == 0
prog_full  output  1  word_cnt >= PROG_FULL
prog_empty  output  1  word_cnt <= PROG_EMPTY
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
err_clr  input  1  synchronous clear of overflow and underflow

Behaviour:
- Accept rules: is_write = data_we & ~full; is_read = data_rd & ~empty. Both are evaluated on pre-edge state.
- Memory: write is synchronous at wr_ptr. Read is combinational, data_o = mem[rd_ptr].
- Read latency: a word written at edge N is visible on data_o after edge N when the FIFO was empty.
- Pointers: ADDR_W bits each, advancing by 1 per accepted op and wrapping naturally at DEPTH-1 -> 0.
- word_cnt update per edge:
  - write only: +1
  - read only: -1
  - both or neither: unchanged
- Flags: full, empty, prog_full and prog_empty are combinational from registered word_cnt, so they update in the cycle after the edge.
- Full boundary: data_we=1 and data_rd=1 while full. The read is accepted, the write is dropped and overflow sets. word_cnt becomes DEPTH-1.
- Empty boundary: both asserted while empty. The write is accepted, the read is rejected and underflow sets. word_cnt becomes 1.
- Sticky flags:
  - overflow sets on data_we & full; underflow sets on data_rd & empty.
  - err_clr clears both. If err_clr and a new error occur in the same cycle, the set wins.
- Reset (including mid-operation) has top priority:
  - wr_ptr, rd_ptr and word_cnt go to 0; overflow and underflow go to 0.
  - Memory contents are not cleared; data_o shows mem[0] (don't-care to consumers).
  - After reset: empty=1, prog_empty=1, full=0, prog_full=0. Requests in the reset cycle are ignored.
- Illegal parameters (DEPTH not a power of two, thresholds out of range) raise an elaboration-time $error.

Optional Feature:
Macro FIFO_PARAM_PEAK_EN.
- Defined: adds output peak_cnt [CNT_W-1:0], a high-water mark.
  - Each edge: if word_cnt > peak_cnt, peak_cnt <= word_cnt.
  - Cleared to 0 by reset_p or err_clr. Clear takes priority over update within the same cycle.
- Not defined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package fifo_param_pkg:
  - typedef struct packed fifo_status_t {full, empty, prog_full, prog_empty, overflow, underflow} for consumers that bundle flags.
  - Function is_pow2() used by the parameter checks.
- Sub-module fifo_param_mem: WIDTH x DEPTH array with synchronous write port and asynchronous read port. Keeping it separate allows later replacement with a vendor RAM.
- Control (pointers, count, flags, error logic) stays in fifo_param.

Test Plan:
1. Reset then idle -> empty=1, prog_empty=1, word_cnt=0, overflow=0, underflow=0; data_rd=1 for one cycle -> underflow=1 next cycle, word_cnt stays 0.
2. Write 0x0001..0x0010 (16 words, one per cycle):
   - prog_empty deasserts after the 3rd write; prog_full asserts after the 14th; full after the 16th.
   - 17th write 0xDEAD -> dropped, overflow=1.
   - 16 reads return 0x0001..0x0010 in order; empty=1 at the end.
3. Wrap-around: 10 writes, 10 reads, then 10 writes of 0x0100+i -> reads return 0x0100..0x0109; pointers crossed 15->0 with no corruption.
4. Simultaneous ops:
   - While full, we=rd=1 -> word_cnt 16->15, overflow=1, head advances.
   - While empty, we=rd=1 with data 0x00AA -> word_cnt=1, underflow=1, data_o=0x00AA.
   - With 5 stored, we=rd=1 -> word_cnt stays 5.
5. Sticky-flag clear:
   - With overflow=1, pulse err_clr -> overflow=0.
   - err_clr together with a write while full -> overflow remains 1.
6. Reset mid-stream: 7 words stored, assert reset_p for 1 cycle alongside data_we=1 -> word_cnt=0, empty=1, the write is not stored. With FIFO_PARAM_PEAK_EN, peak_cnt=7 before reset and 0 after.
